funprof_stats: RTL
==================

# funprof_stats

Per-invocation statistics stage downstream of the function profiler. It watches the decoder's call/return pulses and the profiler's running cycle count, and computes the duration of each completed invocation as the count delta between call and return. It keeps running totals and buffers recent durations in a FIFO that software drains through a valid/ready port.

## Interface
- `DEPTH`, 8: duration FIFO entries; power of two, 2..64.
- `TOT_W`, 48: width of the accumulated-cycles total.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high; clears all state.
- `call` in 1: one-cycle call pulse from the decoder.
- `ret` in 1: one-cycle return pulse from the decoder.
- `count` in 32: profiler running count (`P_Count`).
- `clr` in 1: synchronous clear of statistics, FIFO and overflow flag; same effect as `reset`.
- `dur_valid` out 1: FIFO head holds a duration.
- `dur_data` out 32: FIFO head duration, in cycles.
- `dur_ready` in 1: consumer accepts the head.
- `inv_count` out 16: completed invocations; saturates at 0xFFFF.
- `total` out `TOT_W`: sum of all durations; wraps modulo 2^`TOT_W`.
- `dur_min` out 32: minimum duration (only with `FUNPROF_MINMAX_EN`).
- `dur_max` out 32: maximum duration (only with `FUNPROF_MINMAX_EN`).
- `overflow` out 1: sticky; a duration was dropped because the FIFO was full.
- `active` out 1: high in the IN_CALL state.

## Operation
- **Reset/clr values**
  - State IDLE; `start_cnt`=0.
  - FIFO empty; `dur_valid`=0; `dur_data`=0.
  - `inv_count`=0; `total`=0; `dur_min`=0xFFFF_FFFF; `dur_max`=0.
  - `overflow`=0; `active`=0.
- **FSM states:** IDLE and IN_CALL.
- **IDLE**
  - `call`: `start_cnt`←`count`, go to IN_CALL.
  - `ret` alone: ignored.
  - `call` and `ret` together: treated as `call`.
- **IN_CALL**
  - `ret`: `dur_r`←(`count`−`start_cnt`) mod 2^32, `dur_pend`←1, go to IDLE.
  - `call` alone: re-entry; `start_cnt`←`count` (restart the measurement), no duration produced.
  - `call` and `ret` together: close the current invocation as for `ret`, then `start_cnt`←`count` and stay in IN_CALL.
- **Commit, on the cycle after `dur_pend`**
  - `inv_count`+1, saturating.
  - `total`+=zero-extended `dur_r`.
  - min/max update.
  - Push `dur_r` to the FIFO.
  - If the FIFO is full and there is no same-cycle pop: the push is dropped, `overflow`←1, and the statistics are still updated.
- **FIFO**
  - Show-ahead: `dur_data` is the head whenever `dur_valid`=1.
  - Pop when `dur_valid`&`dur_ready`.
  - Push and pop in the same cycle are legal when full or when non-empty.
  - Pointers are log2(`DEPTH`)+1 bits and wrap naturally.
- **Other**
  - `reset`/`clr` mid-invocation: return to IDLE and discard the invocation.
  - `clr` has priority over a same-cycle commit.
  - Zero duration (call and return in the same count value) is legal and is recorded as 0.

## Timing
- `ret` sampled at edge N → `dur_r` registered at N → commit at N+1.
- `dur_valid`, `inv_count`, `total`, min/max and `overflow` are visible after N+1: latency 2 edges from the `ret` edge.
- `active` rises or falls one edge after the `call`/`ret` edge.
- A `dur_valid`&`dur_ready` handshake at edge M: the next entry (or `dur_valid`=0) appears after M.
- `dur_data` holds stable while `dur_valid`=1 and `dur_ready`=0.
- Back-to-back invocations, one per 2 cycles, sustain without loss while the FIFO is drained.

## Configuration
- `FUNPROF_MINMAX_EN` defined: `dur_min`/`dur_max` ports and comparators are present.
- Undefined: the ports are omitted and no min/max logic is built. All other behaviour is identical.

## Structure
- Shared package `funprof_pkg` holds:
  - FSM state enum (IDLE, IN_CALL);
  - `CNT_W`=32;
  - `INV_W`=16;
  - min/max reset constants.
- One sub-module `funprof_fifo` (parameterised `DEPTH`/width, show-ahead, full/empty). Everything else lives in `funprof_stats`.

## Test plan
- **Single invocation:** `call` at `count`=100, `ret` at `count`=350 → `dur_data`=250, `dur_valid` 2 edges after `ret`, `inv_count`=1, `total`=250, min=max=250.
- **Counter wrap:** `call` at 0xFFFF_FFF0, `ret` at 0x0000_0010 → duration 0x20.
- **Re-entry and simultaneous events:**
  - `call` at 10, `call` at 40, `ret` at 100 → duration 60.
  - In IN_CALL, `call`+`ret` together at 200 with start 150 → duration 50, `active` stays 1.
- **FIFO full:** `dur_ready`=0, `DEPTH`=8, 9 invocations → 8 entries held in order, `overflow`=1, `inv_count`=9; drain with `dur_ready`=1 → 8 handshakes, then `dur_valid`=0.
- **Reset/clr mid-call:** `call`, `reset` for one cycle, `ret` → nothing pushed, `inv_count`=0, `active`=0.
- **Stray and min/max:**
  - `ret` in IDLE → no effect.
  - Durations 30, 5, 90 → min 5, max 90, `total` 125 (with `FUNPROF_MINMAX_EN`).

Source files
------------

// File: rtl/funprof_pkg.sv
// rtl/funprof_pkg.sv - shared types and constants for the function-profiler statistics stage
package funprof_pkg;

    localparam int CNT_W = 32;
    localparam int INV_W = 16;

    // Running minimum starts at the top of the range so the first duration always replaces it
    localparam logic [CNT_W-1:0] DUR_MIN_RST = '1;
    localparam logic [CNT_W-1:0] DUR_MAX_RST = '0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_IN_CALL = 1'b1
    } state_e;

endpackage

// File: rtl/funprof_fifo.sv
// rtl/funprof_fifo.sv - show-ahead duration FIFO with full/empty tracking
module funprof_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = push_i & (~full_o | do_pop);
    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are only observed through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/funprof_stats.sv
// rtl/funprof_stats.sv - per-invocation duration statistics; optional min/max under FUNPROF_MINMAX_EN
module funprof_stats
    import funprof_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TOT_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call,
    input  logic             ret,
    input  logic [CNT_W-1:0] count,
    input  logic             clr,
    output logic             dur_valid,
    output logic [CNT_W-1:0] dur_data,
    input  logic             dur_ready,
    output logic [INV_W-1:0] inv_count,
    output logic [TOT_W-1:0] total,
`ifdef FUNPROF_MINMAX_EN
    output logic [CNT_W-1:0] dur_min,
    output logic [CNT_W-1:0] dur_max,
`endif
    output logic             overflow,
    output logic             active
);

    state_e           state_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] dur_q;
    logic             pend_q;
    logic [INV_W-1:0] inv_q, inv_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;
    logic             sync_clr;
    logic             fifo_full;
    logic             pop;

    assign sync_clr = reset | clr;
    assign pop      = dur_valid & dur_ready;

    // Call/return tracking: captures start count and produces one duration per completed call
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            dur_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (call) begin
                        start_q <= count;
                        state_q <= ST_IN_CALL;
                    end
                end
                ST_IN_CALL: begin
                    if (ret) begin
                        dur_q  <= count - start_q;
                        pend_q <= 1'b1;
                    end
                    if (call) begin
                        start_q <= count;
                    end else if (ret) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign active = (state_q == ST_IN_CALL);

    // Next-state statistics for the commit cycle following a produced duration
    always_comb begin
        inv_d   = inv_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        if (pend_q) begin
            if (inv_q != '1) inv_d = inv_q + 1'b1;
            total_d = total_q + {{(TOT_W-CNT_W){1'b0}}, dur_q};
            if (fifo_full && !pop) ovf_d = 1'b1;
        end
    end

    // Statistics registers; a clear wins over a same-cycle commit
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            inv_q   <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            inv_q   <= inv_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

    assign inv_count = inv_q;
    assign total     = total_q;
    assign overflow  = ovf_q;

`ifdef FUNPROF_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    // Extremes track every committed duration, including ones the FIFO dropped
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (pend_q && dur_q < min_q) min_d = dur_q;
        if (pend_q && dur_q > max_q) max_d = dur_q;
    end

    // Min/max registers
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            min_q <= DUR_MIN_RST;
            max_q <= DUR_MAX_RST;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign dur_min = min_q;
    assign dur_max = max_q;
`endif

    funprof_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W)
    ) u_fifo (
        .clk_i       (clk),
        .clr_i       (sync_clr),
        .push_i      (pend_q),
        .push_data_i (dur_q),
        .pop_i       (pop),
        .valid_o     (dur_valid),
        .data_o      (dur_data),
        .full_o      (fifo_full)
    );

endmodule
